pc_gen_unit: RTL and testbench

//  Parametrised program-counter generator for the pipelined core's fetch stage.

---
 rtl/pc_gen_unit.sv | 150 +++++++++++++++
 tb/tb_pc_gen_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// -----------------------------------------------------------------------------
// pc_gen_unit
//   Program-counter generator for the fetch stage. Each rising clock edge picks
//   the next fetch address, in fixed priority order:
//     trap > redirect > stall > call/return prediction > sequential increment.
//   A circular return-address stack (RAS) is included. Calls push the return
//   address (pc + PC_INC). Returns pop the most recent entry.
//
// Parameters
//   XLEN          address width in bits
//   RESET_VECTOR  pc value while and after reset
//   PC_INC        sequential increment in bytes
//   RAS_DEPTH     RAS entries (power of two, >= 2)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   stall          hold pc (hazard unit)
//   redirect       EX-stage redirect request, target in redirect_addr
//   trap           exception/interrupt request, target in trap_vector
//   call           fetched instruction is a call, target in call_target
//   ret            fetched instruction is a return
//   pc             registered fetch address
//   ras_empty      RAS holds no entries
//   ras_full       RAS holds RAS_DEPTH entries
//   ras_underflow  one-cycle pulse after a return was taken with an empty RAS
// -----------------------------------------------------------------------------
module pc_gen_unit #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              PC_INC       = 4,
    parameter int              RAS_DEPTH    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            call,
    input  logic [XLEN-1:0] call_target,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    // RAS storage. Entries are data only and carry no reset.
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;      // index of the most recent entry
    logic [CNT_W-1:0] ras_count;

    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [XLEN-1:0]  seq;
    logic [XLEN-1:0]  top_entry;

    logic [XLEN-1:0]  pc_next;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;
    logic             do_flush;
    logic             underflow_next;

    // The pointer wraps naturally because RAS_DEPTH is a power of two.
    // When the stack is full, the slot after top holds the oldest entry.
    // That is the slot a push overwrites.
    assign ptr_inc   = top_ptr + PTR_W'(1);
    assign ptr_dec   = top_ptr - PTR_W'(1);
    assign seq       = pc + XLEN'(PC_INC);
    assign top_entry = ras_mem[top_ptr];

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == DEPTH_CNT);

    // ---- select stage: next-pc and RAS operation decode ----
    always_comb begin
        pc_next        = seq;
        do_push        = 1'b0;
        do_pop         = 1'b0;
        do_swap        = 1'b0;
        do_flush       = 1'b0;
        underflow_next = 1'b0;

        if (trap) begin
            pc_next  = trap_vector;
            do_flush = 1'b1;
        end else if (redirect) begin
            pc_next = redirect_addr;
        end else if (stall) begin
            pc_next = pc;
        end else if (call && ret && !ras_empty) begin
            // Tail-call style: consume the top entry and replace it in place.
            // The depth is unchanged.
            pc_next = top_entry;
            do_swap = 1'b1;
        end else if (call) begin
            // This branch also covers call&ret with an empty RAS.
            pc_next = call_target;
            do_push = 1'b1;
        end else if (ret) begin
            if (!ras_empty) begin
                pc_next = top_entry;
                do_pop  = 1'b1;
            end else begin
                underflow_next = 1'b1;
            end
        end
    end

    // ---- register stage: pc and RAS control ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_VECTOR;
            ras_count     <= '0;
            top_ptr       <= '0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_next;
            ras_underflow <= underflow_next;
            if (do_flush) begin
                ras_count <= '0;
            end else if (do_push) begin
                top_ptr <= ptr_inc;
                if (!ras_full) begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (do_pop) begin
                top_ptr   <= ptr_dec;
                ras_count <= ras_count - CNT_W'(1);
            end
        end
    end

    // RAS entry writes. The entries are not reset, so this block has no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ptr_inc] <= seq;
        end else if (do_swap) begin
            ras_mem[top_ptr] <= seq;
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall, redirect, trap, call, ret;
    logic [XLEN-1:0] redirect_addr, trap_vector, call_target;
    logic [XLEN-1:0] pc, pc2;
    logic            ras_empty, ras_full, ras_underflow;
    logic            empty2, full2, uf2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: RAS as a queue, where the back of the queue is the top.
    logic [XLEN-1:0] m_pc;
    logic [XLEN-1:0] m_ras[$];
    logic            m_uf;

    always #5 clk = ~clk;

    pc_gen_unit #(.XLEN(XLEN), .RESET_VECTOR(64'h0), .PC_INC(4), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .trap(trap), .trap_vector(trap_vector),
        .call(call), .call_target(call_target), .ret(ret), .pc(pc),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
    );

    pc_gen_unit #(.XLEN(XLEN), .RESET_VECTOR(64'hFFFF_FFFF_FFFF_FFFC), .PC_INC(4), .RAS_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .trap(trap), .trap_vector(trap_vector),
        .call(call), .call_target(call_target), .ret(ret), .pc(pc2),
        .ras_empty(empty2), .ras_full(full2), .ras_underflow(uf2)
    );

    task automatic set_idle();
        stall = 0; redirect = 0; trap = 0; call = 0; ret = 0;
        redirect_addr = '0; trap_vector = '0; call_target = '0;
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_ras.delete();
        m_uf = 0;
    endtask

    task automatic model_push(input logic [XLEN-1:0] v);
        m_ras.push_back(v);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    endtask

    // Advance the model on the current inputs, then let one clock edge pass.
    task automatic step();
        logic [XLEN-1:0] s;
        s = m_pc + 64'd4;
        m_uf = 0;
        if (trap) begin
            m_pc = trap_vector; m_ras.delete();
        end else if (redirect) begin
            m_pc = redirect_addr;
        end else if (stall) begin
            // hold
        end else if (call && ret && m_ras.size() > 0) begin
            m_pc = m_ras[m_ras.size()-1];
            m_ras[m_ras.size()-1] = s;
        end else if (call) begin
            m_pc = call_target; model_push(s);
        end else if (ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = s; m_uf = 1; end
        end else begin
            m_pc = s;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; #3; rst = 0;
        model_reset();
        @(posedge clk); #1;
        m_pc = m_pc;
    endtask

    task automatic test_reset();
        set_idle();
        call = 1; call_target = 64'h7000;
        step();
        set_idle();
        step(); step();
        // Assert reset between clock edges. It must take effect without a clock.
        #2; rst = 1; #1;
        n_cmp++; if (pc !== 64'h0) begin n_err++; $display("FAIL reset_pc actual=%h required=%h", pc, 64'h0); end
        n_cmp++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_underflow !== 1'b0) begin
            n_err++; $display("FAIL reset_flags actual=%b%b%b required=100", ras_empty, ras_full, ras_underflow); end
        #2; rst = 0;
        model_reset();
        @(posedge clk); #1;
        // pc is still 0 here: this was the first edge after reset released? Recompute from model.
        m_pc = 64'h4;
        n_cmp++; if (pc !== 64'h4) begin n_err++; $display("FAIL reset_seq1 actual=%h required=%h", pc, 64'h4); end
        step();
        n_cmp++; if (pc !== 64'h8) begin n_err++; $display("FAIL reset_seq2 actual=%h required=%h", pc, 64'h8); end
        step();
        n_cmp++; if (pc !== 64'hC) begin n_err++; $display("FAIL reset_seq3 actual=%h required=%h", pc, 64'hC); end
    endtask

    task automatic test_priority();
        set_idle();
        call = 1; call_target = 64'h300;
        step();
        set_idle();
        trap = 1; trap_vector = 64'h100; redirect = 1; redirect_addr = 64'h200;
        stall = 1; call = 1; call_target = 64'h400;
        step();
        set_idle();
        n_cmp++; if (pc !== 64'h100) begin n_err++; $display("FAIL trap_pc actual=%h required=%h", pc, 64'h100); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL trap_flush actual=%b required=1", ras_empty); end
        redirect = 1; redirect_addr = 64'h240; stall = 1; call = 1; call_target = 64'h999; ret = 1;
        step();
        set_idle();
        n_cmp++; if (pc !== 64'h240 || ras_empty !== 1'b1) begin
            n_err++; $display("FAIL redirect_prio actual=%h/%b required=%h/1", pc, ras_empty, 64'h240); end
    endtask

    task automatic test_call_ret();
        set_idle();
        redirect = 1; redirect_addr = 64'h20;
        step();
        set_idle();
        n_cmp++; if (pc !== 64'h20) begin n_err++; $display("FAIL cr_start actual=%h required=%h", pc, 64'h20); end
        call = 1; call_target = 64'h400;
        step();
        set_idle();
        n_cmp++; if (pc !== 64'h400 || ras_empty !== 1'b0) begin
            n_err++; $display("FAIL cr_call actual=%h/%b required=%h/0", pc, ras_empty, 64'h400); end
        step();
        n_cmp++; if (pc !== 64'h404) begin n_err++; $display("FAIL cr_idle actual=%h required=%h", pc, 64'h404); end
        ret = 1;
        step();
        set_idle();
        n_cmp++; if (pc !== 64'h24 || ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
            n_err++; $display("FAIL cr_ret actual=%h/%b/%b required=%h/1/0", pc, ras_empty, ras_underflow, 64'h24); end
    endtask

    task automatic test_overflow();
        logic [XLEN-1:0] a;
        set_idle();
        redirect = 1; redirect_addr = 64'h1000;
        step();
        set_idle();
        // Call i is made from pc 0x1000*(i+1) and targets the next such address.
        for (int i = 0; i < DEPTH + 2; i++) begin
            call = 1; call_target = 64'h1000 * (i + 2);
            step();
            n_cmp++; if (ras_full !== (i >= DEPTH - 1)) begin
                n_err++; $display("FAIL ovf_full%0d actual=%b required=%b", i, ras_full, (i >= DEPTH - 1)); end
        end
        set_idle();
        for (int i = DEPTH + 1; i >= 2; i--) begin
            ret = 1;
            step();
            a = 64'h1000 * (i + 1) + 64'd4;
            n_cmp++; if (pc !== a) begin n_err++; $display("FAIL ovf_ret%0d actual=%h required=%h", i, pc, a); end
        end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty actual=%b required=1", ras_empty); end
        step();
        set_idle();
        n_cmp++; if (pc !== 64'h3008 || ras_underflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_under actual=%h/%b required=%h/1", pc, ras_underflow, 64'h3008); end
        step();
        n_cmp++; if (ras_underflow !== 1'b0 || pc !== 64'h300C) begin
            n_err++; $display("FAIL ovf_pulse actual=%h/%b required=%h/0", pc, ras_underflow, 64'h300C); end
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] held;
        set_idle();
        redirect = 1; redirect_addr = 64'h5000;
        step();
        set_idle();
        call = 1; call_target = 64'h6000;
        step();
        set_idle();
        stall = 1; call = 1; call_target = 64'h9990; held = pc;
        step();
        n_cmp++; if (pc !== held) begin n_err++; $display("FAIL stall_hold actual=%h required=%h", pc, held); end
        set_idle();
        stall = 1; redirect = 1; redirect_addr = 64'h80;
        step();
        set_idle();
        n_cmp++; if (pc !== 64'h80) begin n_err++; $display("FAIL stall_redir actual=%h required=%h", pc, 64'h80); end
        ret = 1;
        step();
        set_idle();
        n_cmp++; if (pc !== 64'h5004 || ras_empty !== 1'b1) begin
            n_err++; $display("FAIL stall_ras actual=%h/%b required=%h/1", pc, ras_empty, 64'h5004); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            trap          = ($urandom_range(0, 31) == 0);
            redirect      = ($urandom_range(0, 7) == 0);
            stall         = ($urandom_range(0, 5) == 0);
            call          = ($urandom_range(0, 2) == 0);
            ret           = ($urandom_range(0, 2) == 0);
            trap_vector   = {$urandom, $urandom};
            redirect_addr = {$urandom, $urandom};
            call_target   = {$urandom, $urandom};
            step();
            n_cmp++;
            if (pc !== m_pc || ras_empty !== (m_ras.size() == 0) ||
                ras_full !== (m_ras.size() == DEPTH) || ras_underflow !== m_uf) begin
                n_err++;
                $display("FAIL rand%0d actual=%h/%b%b%b required=%h/%b%b%b", i, pc, ras_empty, ras_full,
                         ras_underflow, m_pc, (m_ras.size() == 0), (m_ras.size() == DEPTH), m_uf);
            end
        end
        set_idle();
    endtask

    task automatic test_wrap();
        set_idle();
        rst = 1; #3;
        n_cmp++; if (pc2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_err++; $display("FAIL wrap_reset actual=%h required=%h", pc2, 64'hFFFF_FFFF_FFFF_FFFC); end
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        m_pc = 64'h4;
        n_cmp++; if (pc2 !== 64'h0) begin n_err++; $display("FAIL wrap_zero actual=%h required=%h", pc2, 64'h0); end
        call = 1; call_target = 64'h500;
        step();
        n_cmp++; if (pc2 !== 64'h500) begin n_err++; $display("FAIL wrap_call actual=%h required=%h", pc2, 64'h500); end
        call = 1; ret = 1; call_target = 64'h777;
        step();
        set_idle();
        n_cmp++; if (pc2 !== 64'h4 || empty2 !== 1'b0) begin
            n_err++; $display("FAIL wrap_cr actual=%h/%b required=%h/0", pc2, empty2, 64'h4); end
        ret = 1;
        step();
        set_idle();
        n_cmp++; if (pc2 !== 64'h504 || empty2 !== 1'b1) begin
            n_err++; $display("FAIL wrap_top actual=%h/%b required=%h/1", pc2, empty2, 64'h504); end
        call = 1; ret = 1; call_target = 64'h600;
        step();
        set_idle();
        n_cmp++; if (pc2 !== 64'h600 || empty2 !== 1'b0 || uf2 !== 1'b0) begin
            n_err++; $display("FAIL wrap_cr_empty actual=%h/%b/%b required=%h/0/0", pc2, empty2, uf2, 64'h600); end
        ret = 1;
        step();
        set_idle();
        n_cmp++; if (pc2 !== 64'h508 || full2 !== 1'b0) begin
            n_err++; $display("FAIL wrap_ret2 actual=%h/%b required=%h/0", pc2, full2, 64'h508); end
    endtask

    initial begin
        set_idle();
        rst = 1;
        model_reset();
        #12; rst = 0;
        @(posedge clk); #1;
        m_pc = 64'h4;
        test_reset();
        test_priority();
        test_call_ret();
        test_overflow();
        test_stall();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
